// File: rtl/cs_seq_arbiter_pkg.sv
// Shared state encoding and sizing helpers for the chip-select sequencer.
package cs_seq_arbiter_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    // Counter width able to hold maxv with one bit of headroom.
    function automatic int cnt_w(input int maxv);
        return $clog2(maxv) + 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cs_seq_arbiter_if.sv
// Requester-side bus: level requests, per-requester frame data, grant/done/busy.
interface cs_seq_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;

    modport master (output req, wdata, input grant, done, busy);
    modport slave  (input req, wdata, output grant, done, busy);
endinterface

// File: rtl/cs_seq_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, cyclic.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    // Scan from the pointer upward and wrap; the first hit wins.
    always_comb begin : pick
        logic          found;
        logic [PW-1:0] idx;
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cs_seq_arbiter.sv
// Round-robin shared chip-select serial master: arbitrates, then runs one
// CS/SCLK/SDO frame (setup, MSB-first shift, hold, gap) for the winner.
module cs_seq_arbiter
    import cs_seq_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 16,
    parameter int CLK_DIV = 4,
    parameter int T_SETUP = 2,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 4
) (
    input  logic               clk,
    input  logic               rst,
    cs_seq_arbiter_if.slave    bus,
    output logic               cs_o,
    output logic               sclk_o,
    output logic               sdo_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int TMAX = max2(max2(CLK_DIV, T_SETUP), max2(T_HOLD, T_GAP));
    localparam int TW   = cnt_w(TMAX);
    localparam int BW   = cnt_w(DW);
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q;
    logic [TW-1:0]     tmr_q;
    logic [BW-1:0]     bit_q;
    logic              sclk_q;
    logic              cs_q;
    logic              busy_q;
    logic [DW-1:0]     shreg_q;
    logic [NREQ-1:0]   grant_q;
    logic [NREQ-1:0]   done_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     gidx_q;

    logic [NREQ-1:0]   gnt_d;
    logic [PW-1:0]     gidx_d;
    logic [DW-1:0]     words [NREQ];

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (gnt_d)
    );

    for (genvar i = 0; i < NREQ; i++) begin : g_words
        assign words[i] = bus.wdata[i*DW +: DW];
    end

    // Encode the one-hot winner so its index can seed the next pointer.
    always_comb begin
        gidx_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_d[i]) gidx_d = PW'(i);
        end
    end

    // Frame sequencer; every pin and status output comes straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            shreg_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (|bus.req) begin
                        grant_q <= gnt_d;
                        gidx_q  <= gidx_d;
                        shreg_q <= words[gidx_d];
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        tmr_q   <= '0;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (tmr_q == TW'(T_SETUP - 1)) begin
                        tmr_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_SHIFT;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (tmr_q == TW'(CLK_DIV - 1)) begin
                        tmr_q  <= '0;
                        sclk_q <= ~sclk_q;
                        // Falling edge: advance to the next bit.
                        if (sclk_q) begin
                            shreg_q <= {shreg_q[DW-2:0], 1'b0};
                            if (bit_q == BW'(DW - 1)) begin
                                state_q <= S_HOLD;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (tmr_q == TW'(T_HOLD - 1)) begin
                        tmr_q   <= '0;
                        cs_q    <= 1'b1;
                        state_q <= S_GAP;
                        if (T_GAP == 1) done_q <= grant_q;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (tmr_q == TW'(T_GAP - 1)) begin
                        tmr_q   <= '0;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                        // Raise done so it is visible during the final gap cycle.
                        if (T_GAP > 1 && tmr_q == TW'(T_GAP - 2)) done_q <= grant_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign cs_o      = cs_q;
    assign sclk_o    = sclk_q;
    assign sdo_o     = shreg_q[DW-1];
    assign state_o   = state_q;

endmodule

// File: tb/tb_cs_seq_arbiter.sv
// Directed bench for cs_seq_arbiter at default parameters.
module tb_cs_seq_arbiter;

    logic       clk;
    logic       rst;
    logic       cs_o;
    logic       sclk_o;
    logic       sdo_o;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    cs_seq_arbiter_if #(.NREQ(4), .DW(16)) bus ();

    cs_seq_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cs_o    (cs_o),
        .sclk_o  (sclk_o),
        .sdo_o   (sdo_o),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req = '0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Expects req already driven; watches one full frame from grant to IDLE.
    task automatic run_frame(input string tag, input logic [3:0] exp_g,
                             input logic [15:0] exp_w, input bit mid_mod);
        logic [15:0] cap;
        logic [3:0]  done_v;
        logic        prev_sclk;
        int          rises;
        int          done_cnt;
        int          done_k;
        int          idle_k;
        cap = '0; done_v = '0; rises = 0; done_cnt = 0; done_k = -1; idle_k = -1;
        step(1);
        check({tag, "_gnt"}, 32'(bus.grant), 32'(exp_g));
        check({tag, "_cs"}, 32'(cs_o), 32'd0);
        check({tag, "_st"}, 32'(state_o), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        prev_sclk = sclk_o;
        for (int k = 1; k <= 200 && idle_k < 0; k++) begin
            step(1);
            if (sclk_o && !prev_sclk) begin
                cap = {cap[14:0], sdo_o};
                rises++;
            end
            prev_sclk = sclk_o;
            if (bus.done != 4'b0) begin
                done_cnt++;
                done_k = k;
                done_v = bus.done;
            end
            if (state_o == 3'd0) idle_k = k;
            if (mid_mod && k == 40) begin
                bus.req = 4'b0000;
                bus.wdata[15:0] = 16'hFFFF;
            end
        end
        check({tag, "_word"}, 32'(cap), 32'(exp_w));
        check({tag, "_rises"}, 32'(rises), 32'd16);
        check({tag, "_donecnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_donev"}, 32'(done_v), 32'(exp_g));
        check({tag, "_donek"}, 32'(done_k), 32'd135);
        check({tag, "_idlek"}, 32'(idle_k), 32'd136);
        check({tag, "_gnt_end"}, 32'(bus.grant), 32'd0);
        check({tag, "_cs_end"}, 32'(cs_o), 32'd1);
    endtask

    initial begin : stim
        logic dseen;
        bus.req   = '0;
        bus.wdata = {16'hC001, 16'h0F0F, 16'hBEEF, 16'h1234};
        do_reset();

        // Reset state and idle with no requests
        check("t1_cs", 32'(cs_o), 32'd1);
        check("t1_sclk", 32'(sclk_o), 32'd0);
        check("t1_sdo", 32'(sdo_o), 32'd0);
        check("t1_gnt", 32'(bus.grant), 32'd0);
        check("t1_done", 32'(bus.done), 32'd0);
        check("t1_busy", 32'(bus.busy), 32'd0);
        check("t1_st", 32'(state_o), 32'd0);
        step(5);
        check("t1_st_idle", 32'(state_o), 32'd0);
        check("t1_cs_idle", 32'(cs_o), 32'd1);

        // Single requester frame
        bus.wdata[15:0] = 16'hA5C3;
        bus.req = 4'b0001;
        run_frame("t2", 4'b0001, 16'hA5C3, 1'b0);
        bus.req = 4'b0000;

        // All requesting: rotation from pointer 0
        do_reset();
        bus.wdata = {16'hC001, 16'h0F0F, 16'hBEEF, 16'h1234};
        bus.req = 4'b1111;
        run_frame("t3a", 4'b0001, 16'h1234, 1'b0);
        run_frame("t3b", 4'b0010, 16'hBEEF, 1'b0);
        run_frame("t3c", 4'b0100, 16'h0F0F, 1'b0);
        run_frame("t3d", 4'b1000, 16'hC001, 1'b0);
        run_frame("t3e", 4'b0001, 16'h1234, 1'b0);
        bus.req = 4'b0000;

        // Pointer at 2, then requests 0 and 3
        do_reset();
        bus.req = 4'b0001;
        run_frame("t4a", 4'b0001, 16'h1234, 1'b0);
        bus.req = 4'b0010;
        run_frame("t4b", 4'b0010, 16'hBEEF, 1'b0);
        bus.req = 4'b1001;
        run_frame("t4c", 4'b1000, 16'hC001, 1'b0);
        run_frame("t4d", 4'b0001, 16'h1234, 1'b0);
        bus.req = 4'b0000;

        // req dropped and data changed mid-shift
        bus.wdata[15:0] = 16'h6D2B;
        bus.req = 4'b0001;
        run_frame("t5", 4'b0001, 16'h6D2B, 1'b1);
        bus.req = 4'b0000;

        // Async reset mid-shift
        bus.wdata[15:0] = 16'h5A5A;
        bus.req = 4'b0001;
        step(1);
        check("t6_gnt", 32'(bus.grant), 32'd1);
        step(31);
        check("t6_sclk_pre", 32'(sclk_o), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_cs", 32'(cs_o), 32'd1);
        check("t6_sclk", 32'(sclk_o), 32'd0);
        check("t6_gnt0", 32'(bus.grant), 32'd0);
        check("t6_st", 32'(state_o), 32'd0);
        check("t6_busy", 32'(bus.busy), 32'd0);
        bus.req = 4'b0000;
        dseen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (bus.done != 4'b0) dseen = 1'b1;
        end
        check("t6_nodone", 32'(dseen), 32'd0);
        rst = 1'b1;
        bus.wdata[15:0] = 16'h3C96;
        bus.req = 4'b0011;
        run_frame("t6b", 4'b0001, 16'h3C96, 1'b0);
        bus.req = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so a stuck design still ends the run.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
